// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin picker.
package dmem_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int unsigned MEM_BYTES_DEFAULT = 4096;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        port;
  } cmd_t;

  // Rejected when misaligned or outside the memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] != 2'b00) || (addr >= 32'(mem_bytes));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-granted port loses a tie.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt          = 2'b00;
    gnt_id       = PORT_CORE;
    last_grant_d = last_grant_q;
    if (en && (req0 || req1)) begin
      if (req0 && req1) begin
        gnt_id = (last_grant_q == PORT_DBG) ? PORT_CORE : PORT_DBG;
      end else if (req1) begin
        gnt_id = PORT_DBG;
      end else begin
        gnt_id = PORT_CORE;
      end
      gnt          = (gnt_id == PORT_DBG) ? 2'b10 : 2'b01;
      last_grant_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single-ported data memory, one access per two cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        bad_q, bad_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        arb_en;
  logic [1:0]  arb_gnt;
  logic        arb_id;

  assign arb_en = (state_q == StIdle);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bad_d    = bad_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (arb_gnt != 2'b00) begin
          gnt_d       = arb_gnt;
          cmd_d.port  = arb_id;
          cmd_d.we    = (arb_id == PORT_DBG) ? we1 : we0;
          cmd_d.addr  = (arb_id == PORT_DBG) ? addr1 : addr0;
          cmd_d.wdata = (arb_id == PORT_DBG) ? wdata1 : wdata0;
          bad_d       = addr_bad(cmd_d.addr, MEM_BYTES);
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (cmd_q.port == PORT_DBG) begin
          done_d[1] = 1'b1;
          err_d[1]  = bad_q;
        end else begin
          done_d[0] = 1'b1;
          err_d[0]  = bad_q;
        end
        if (!cmd_q.we && !bad_q) begin
          if (cmd_q.port == PORT_DBG) begin
            rdata1_d = mem_read_data;
          end else begin
            rdata0_d = mem_read_data;
          end
        end
        state_d = StIdle;
      end
    endcase
  end

  // Write is gated by rst so an access interrupted by reset never commits.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (state_q == StAccess) begin
      mem_address    = cmd_q.addr;
      mem_write_data = cmd_q.wdata;
      mem_write      = cmd_q.we & ~bad_q & ~rst;
      mem_read       = ~cmd_q.we & ~bad_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      bad_q    <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      bad_q    <= bad_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model and a memory stub.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .done0          (done0),
    .done1          (done1),
    .err0           (err0),
    .err1           (err1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i >= 64 && i <= 67) return 32'hC0DE_0000 + 32'(i);
    if (i == 1) return 32'hA5A5_0004;
    return 32'h0;
  endfunction

  // Memory stub: 1024 words, combinational read, write at the clock edge.
  logic [31:0] ram    [0:1023];
  bit          ram_ok [0:1023];

  function automatic logic [31:0] ram_word(input int i);
    return ram_ok[i] ? ram[i] : init_word(i);
  endfunction

  assign mem_read_data = ram_word(int'(mem_address[11:2]));

  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_address[11:2]]    <= mem_write_data;
      ram_ok[mem_address[11:2]] <= 1'b1;
    end
  end

  // Reference model: one outstanding transaction, completing one edge after its grant.
  int          cyc = 0;
  logic [1:0]  m_gnt, m_done, m_err;
  logic        m_busy, m_last, m_port, m_we, m_bad;
  logic [31:0] m_addr, m_wdata, m_rdata0, m_rdata1;
  logic [31:0] ref_mem [0:1023];
  bit          ref_ok  [0:1023];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int i;
    i = int'(a[11:2]);
    return ref_ok[i] ? ref_mem[i] : init_word(i);
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == 1'b1) ? 1'b0 : 1'b1;
    return r0 ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_gnt  <= 2'b00;
    m_done <= 2'b00;
    m_err  <= 2'b00;
    if (rst) begin
      m_busy   <= 1'b0;
      m_last   <= 1'b1;
      m_rdata0 <= 32'h0;
      m_rdata1 <= 32'h0;
    end else if (m_busy) begin
      m_busy         <= 1'b0;
      m_done[m_port] <= 1'b1;
      m_err[m_port]  <= m_bad;
      if (!m_bad && m_we) begin
        ref_mem[m_addr[11:2]] <= m_wdata;
        ref_ok[m_addr[11:2]]  <= 1'b1;
      end else if (!m_bad && m_port == 1'b0) begin
        m_rdata0 <= ref_word(m_addr);
      end else if (!m_bad) begin
        m_rdata1 <= ref_word(m_addr);
      end
    end else if (req0 || req1) begin
      m_last <= pick(req0, req1, m_last);
      m_port <= pick(req0, req1, m_last);
      m_gnt[pick(req0, req1, m_last)] <= 1'b1;
      m_we    <= pick(req0, req1, m_last) ? we1 : we0;
      m_addr  <= pick(req0, req1, m_last) ? addr1 : addr0;
      m_wdata <= pick(req0, req1, m_last) ? wdata1 : wdata0;
      m_bad   <= pick(req0, req1, m_last) ?
                 ((addr1 % 4) != 0 || addr1 >= 32'd4096) :
                 ((addr0 % 4) != 0 || addr0 >= 32'd4096);
      m_busy  <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("gnt0", gnt0, m_gnt[0]);
      chk("gnt1", gnt1, m_gnt[1]);
      chk("done0", done0, m_done[0]);
      chk("done1", done1, m_done[1]);
      if (m_done[0]) chk("err0", err0, m_err[0]);
      if (m_done[1]) chk("err1", err1, m_err[1]);
      chk("rdata0", rdata0, m_rdata0);
      chk("rdata1", rdata1, m_rdata1);
      chk("mem_write", mem_write, m_busy && m_we && !m_bad && !rst);
      chk("mem_read", mem_read, m_busy && !m_we && !m_bad);
      chk("mem_address", mem_address, m_busy ? m_addr : 32'h0);
      chk("mem_write_data", mem_write_data, m_busy ? m_wdata : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_access(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    bit seen;
    seen = 0;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if ((p == 0) ? gnt0 : gnt1) seen = 1;
    end
    chk("gnt_seen", 32'(seen), 32'd1);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic g0 [1:8];
    logic g1 [1:8];
    int   prev;
    bit   seen;

    tick();
    tick();
    rst = 1'b0;

    // Single write then read back through the other port.
    do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr_done0", done0, 1'b1);
    chk("wr_err0", err0, 1'b0);
    chk("wr_ram10", ram_word(4), 32'hDEAD_BEEF);
    do_access(1, 1'b0, 32'h10, 32'h0);
    chk("rd_done1", done1, 1'b1);
    chk("rd_rdata1", rdata1, 32'hDEAD_BEEF);

    // Conflict straight out of reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    for (int i = 1; i <= 8; i++) begin
      tick();
      g0[i] = gnt0;
      g1[i] = gnt1;
      if (i == 7) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("cf_e1_gnt0", g0[1], 1'b1); chk("cf_e1_gnt1", g1[1], 1'b0);
    chk("cf_e3_gnt0", g0[3], 1'b0); chk("cf_e3_gnt1", g1[3], 1'b1);
    chk("cf_e5_gnt0", g0[5], 1'b1); chk("cf_e5_gnt1", g1[5], 1'b0);
    chk("cf_e7_gnt0", g0[7], 1'b0); chk("cf_e7_gnt1", g1[7], 1'b1);
    chk("cf_e2_idle", {g0[2], g1[2]}, 2'b00);
    tick();

    // Misaligned write is rejected and memory keeps its old word.
    do_access(1, 1'b1, 32'h6, 32'h1234_5678);
    chk("mis_done1", done1, 1'b1);
    chk("mis_err1", err1, 1'b1);
    do_access(0, 1'b0, 32'h4, 32'h0);
    chk("mis_rdata0", rdata0, 32'hA5A5_0004);
    chk("mis_err0", err0, 1'b0);

    // Out-of-range read is rejected and rdata holds.
    do_access(0, 1'b0, 32'h1000, 32'h0);
    chk("oor_err0", err0, 1'b1);
    chk("oor_rdata0", rdata0, 32'hA5A5_0004);

    // Reset during the access cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h5;
    tick();
    chk("rst_gnt0", gnt0, 1'b1);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    chk("rst_nodone0", done0, 1'b0);
    rst = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    tick();
    chk("rst_cf_gnt0", gnt0, 1'b1);
    chk("rst_cf_gnt1", gnt1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    chk("rst_ram20", ram_word(8), 32'h0);

    // Back-to-back reads from port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
        tick();
        if (gnt0) seen = 1;
      end
      chk("b2b_gnt_seen", 32'(seen), 32'd1);
      if (k < 3) addr0 = 32'h100 + 32'(4 * (k + 1));
      else       req0 = 1'b0;
      tick();
      chk("b2b_done0", done0, 1'b1);
      chk("b2b_rdata0", rdata0, 32'hC0DE_0040 + 32'(k));
      if (k > 0) chk("b2b_spacing", 32'(cyc - prev), 32'd2);
      prev = cyc;
    end

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-ported 4 KB data memory. Port 0 is the core load/store unit, port 1 is the debug/DMA loader. Each access is serialised through a two-state FSM, drives the memory's address/write_data/mem_write/mem_read inputs for exactly one cycle, and returns read data or an error flag to the winning requester.

## Interface
- MEM_BYTES, 4096: addressable bytes; any address >= MEM_BYTES is rejected with an error.
- clk  in  1  rising-edge clock shared with data memory.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held with its command fields until the matching gnt is seen high.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  byte address; must be word-aligned.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  one-cycle pulse; the command was accepted.
- done0 / done1  out  1  one-cycle pulse; the access completed.
- err0 / err1  out  1  valid with done; the access was rejected (misaligned or out of range).
- rdata0 / rdata1  out  32  read data, valid when done=1 and the command was a read; otherwise holds its last value.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_write  out  1  to memory mem_write.
- mem_read  out  1  to memory mem_read.
- mem_read_data  in  32  from memory read_data (combinational).

## Operation
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE, no request: stay in IDLE. All outputs are 0.
- IDLE, one request: grant it.
- IDLE, both requests: grant the port that is not last_grant.
  - last_grant resets to 1, so port 0 wins the first conflict.
  - last_grant updates on every grant.
- On grant, at the clock edge:
  - assert gnt for that port;
  - latch we, addr and wdata into cmd registers, plus the port id;
  - compute bad = (addr[1:0] != 0) || (addr >= MEM_BYTES);
  - go to ACCESS.
- ACCESS cycle, memory drive (combinational from cmd registers):
  - mem_address = cmd_addr;
  - mem_write_data = cmd_wdata;
  - mem_write = cmd_we & !bad & !rst;
  - mem_read = !cmd_we & !bad.
- ACCESS, at the closing edge:
  - if the command was a good read, capture mem_read_data into that port's rdata;
  - pulse done for that port, with err = bad;
  - return to IDLE.
- Requests seen while in ACCESS are ignored and re-evaluated in IDLE.
- Outside ACCESS, all mem_* outputs are 0.
- A rejected command never reaches memory and leaves rdata unchanged.

## Timing
- Cycle t: req sampled high in IDLE.
- Edge t+1: gnt=1 for one cycle; memory is driven during cycle t+1.
- Edge t+2: memory write commits, done/err/rdata update; FSM is back in IDLE.
- Latency from req to done: 2 cycles. Peak throughput: one access per 2 cycles.
- Requester rules:
  - keep req high through the cycle gnt is seen (t+1);
  - drop req at t+2 unless another access is wanted;
  - a req still high at t+2 is treated as a new request.
- gnt, done and err are registered single-cycle pulses; they are never high for two consecutive cycles on the same port.
- Reset:
  - at the first edge with rst=1, all registered outputs clear to 0, the FSM goes to IDLE and last_grant goes to 1;
  - rdata registers reset to 0.
- Reset asserted during ACCESS:
  - mem_write is gated by rst, so no write commits;
  - done is not pulsed;
  - the access is lost and the requester must re-request.

## Structure
- Shared package dmem_pkg holds:
  - state encoding (IDLE, ACCESS);
  - port-id constants PORT_CORE=0 and PORT_DBG=1;
  - the default MEM_BYTES value.
- Sub-module rr_arb2 contains the 2-way round-robin pick plus the last_grant register. Inputs are req0/req1 and an enable; outputs are a one-hot grant and the winning port id.
- FSM, cmd registers, error check and memory drive stay in dmem_arbiter. Instantiate alongside data_memory in the top level.

## Test plan
- Single write: port 0 writes 0xDEADBEEF to 0x10 → gnt0 at t+1, mem_write high in cycle t+1 only, done0 at t+2 with err0=0. A subsequent port 1 read of 0x10 returns rdata1=0xDEADBEEF.
- Conflict after reset: req0 and req1 both high from cycle 0 and held → grants go 0, 1, 0, 1 on edges 1, 3, 5, 7; no cycle has two gnts.
- Misaligned access: port 1 writes to address 0x06 → done1=1 and err1=1 at t+2, mem_write never asserts, a later read of 0x04 returns its old value.
- Out-of-range access: port 0 reads 0x1000 → err0=1, mem_read stays 0, rdata0 unchanged.
- Reset mid-access: rst=1 during the ACCESS cycle of a write of 0x5 to 0x20 → no done pulse, memory word 0x20 stays 0. After release, the first conflict is granted to port 0.
- Back-to-back from one port: req0 held high with four different read addresses, updated after each gnt0 → done0 every 2 cycles, and rdata0 matches the preloaded memory contents in order.
